// File: rtl/dff_write_arbiter.sv
// Round-robin arbiter that owns the d-input of one shared WIDTH-bit register.
// One pending requester is captured per grant, followed by an optional HOLD cooldown.
module dff_write_arbiter #(
  parameter int unsigned N           = 4,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           req,
  input  logic [N*WIDTH-1:0]     data,
  output logic [N-1:0]           gnt,
  output logic [WIDTH-1:0]       y,
  output logic                   y_valid,
  output logic [$clog2(N)-1:0]   owner,
  output logic                   busy
);

  localparam int unsigned OW = $clog2(N);
  localparam int unsigned CW = $clog2(HOLD_CYCLES + 2);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state_q;
  logic [OW-1:0]   ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [N-1:0]    gnt_q;
  logic [WIDTH-1:0] y_q;
  logic            y_valid_q;
  logic [OW-1:0]   owner_q;
  logic            busy_q;

  logic            found_d;
  logic [OW-1:0]   win_d;
  int unsigned     idx;

  // Scan ptr, ptr+1, ... with wrap; first pending requester wins.
  always_comb begin
    found_d = 1'b0;
    win_d   = '0;
    idx     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = {{(32-OW){1'b0}}, ptr_q} + i;
      if (idx >= N) idx = idx - N;
      if (!found_d && req[idx[OW-1:0]]) begin
        found_d = 1'b1;
        win_d   = idx[OW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      owner_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      gnt_q     <= '0;
      y_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (found_d) begin
            y_q          <= data[win_d*WIDTH +: WIDTH];
            gnt_q[win_d] <= 1'b1;
            y_valid_q    <= 1'b1;
            owner_q      <= win_d;
            ptr_q        <= (win_d == OW'(N-1)) ? '0 : win_d + 1'b1;
            if (HOLD_CYCLES > 0) begin
              state_q <= HOLD;
              cnt_q   <= CW'(HOLD_CYCLES);
              busy_q  <= 1'b1;
            end
          end
        end
        HOLD: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign owner   = owner_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_dff_write_arbiter.sv
// Directed bench: one arbiter with a 2-cycle cooldown, one with back-to-back grants.
module tb_dff_write_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_a, req_b;
  logic [31:0] data_a, data_b;
  logic [3:0]  gnt_a, gnt_b;
  logic [7:0]  y_a, y_b;
  logic        yv_a, yv_b;
  logic [1:0]  own_a, own_b;
  logic        busy_a, busy_b;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  dff_write_arbiter #(.N(4), .WIDTH(8), .HOLD_CYCLES(2)) u_hold2 (
    .clk(clk), .reset(reset), .req(req_a), .data(data_a),
    .gnt(gnt_a), .y(y_a), .y_valid(yv_a), .owner(own_a), .busy(busy_a)
  );

  dff_write_arbiter #(.N(4), .WIDTH(8), .HOLD_CYCLES(0)) u_hold0 (
    .clk(clk), .reset(reset), .req(req_b), .data(data_b),
    .gnt(gnt_b), .y(y_b), .y_valid(yv_b), .owner(own_b), .busy(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [3:0] g, input logic [7:0] yy,
                       input logic v, input logic [1:0] o, input logic b);
    chk({tag, ".gnt"},   {28'd0, gnt_a}, {28'd0, g});
    chk({tag, ".y"},     {24'd0, y_a},   {24'd0, yy});
    chk({tag, ".vld"},   {31'd0, yv_a},  {31'd0, v});
    chk({tag, ".owner"}, {30'd0, own_a}, {30'd0, o});
    chk({tag, ".busy"},  {31'd0, busy_a}, {31'd0, b});
  endtask

  task automatic chk_b(input string tag, input logic [3:0] g, input logic [7:0] yy,
                       input logic v, input logic [1:0] o);
    chk({tag, ".gnt"},   {28'd0, gnt_b}, {28'd0, g});
    chk({tag, ".y"},     {24'd0, y_b},   {24'd0, yy});
    chk({tag, ".vld"},   {31'd0, yv_b},  {31'd0, v});
    chk({tag, ".owner"}, {30'd0, own_b}, {30'd0, o});
    chk({tag, ".busy"},  {31'd0, busy_b}, 32'd0);
  endtask

  logic [3:0] rot_g [0:8];
  logic [7:0] rot_y [0:8];
  logic [3:0] rot_r [0:8];

  initial begin
    reset = 1'b1;
    req_a = 4'b1111;
    req_b = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      data_a[i*8 +: 8] = 8'h20 + 8'(i);
      data_b[i*8 +: 8] = 8'h10 + 8'(i);
    end

    // Reset held two edges with all requests high
    for (int c = 0; c < 2; c++) begin
      tick();
      chk_a("rst_a", 4'b0000, 8'h00, 1'b0, 2'd0, 1'b0);
      chk_b("rst_b", 4'b0000, 8'h00, 1'b0, 2'd0);
    end
    reset = 1'b0;

    tick();
    chk_a("first_a", 4'b0001, 8'h20, 1'b1, 2'd0, 1'b1);
    chk_b("first_b", 4'b0001, 8'h10, 1'b1, 2'd0);
    req_a = 4'b0000;

    // Back-to-back rotation, then wrap priority once ptr returns to 0
    rot_r = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'b1010, 4'b1010};
    rot_g = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b1000};
    rot_y = '{8'h11, 8'h12, 8'h13, 8'h10, 8'h11, 8'h12, 8'h13, 8'h11, 8'h13};
    for (int s = 0; s < 9; s++) begin
      req_b = rot_r[s];
      tick();
      chk_b($sformatf("rot%0d", s), rot_g[s], rot_y[s], 1'b1, rot_g[s][3] ? 2'd3 :
            rot_g[s][2] ? 2'd2 : rot_g[s][1] ? 2'd1 : 2'd0);
    end
    req_b = 4'b0000;
    tick();
    chk_b("b_idle", 4'b0000, 8'h13, 1'b0, 2'd3);
    chk_a("a_idle", 4'b0000, 8'h20, 1'b0, 2'd0, 1'b0);

    // Single requester held continuously: grant every 3 cycles, data sampled at grant only
    req_a = 4'b0100;
    data_a[23:16] = 8'hA5;
    tick();
    chk_a("single_g1", 4'b0100, 8'hA5, 1'b1, 2'd2, 1'b1);
    data_a[23:16] = 8'h5A;
    tick();
    chk_a("single_h1", 4'b0000, 8'hA5, 1'b0, 2'd2, 1'b1);
    tick();
    chk_a("single_h2", 4'b0000, 8'hA5, 1'b0, 2'd2, 1'b0);
    req_a = 4'b0000;
    req_a[2] = 1'b1;
    tick();
    chk_a("single_g2", 4'b0100, 8'h5A, 1'b1, 2'd2, 1'b1);

    // Request raised and dropped inside HOLD is never served
    req_a = 4'b0010;
    tick();
    chk_a("hwin_h1", 4'b0000, 8'h5A, 1'b0, 2'd2, 1'b1);
    req_a = 4'b0000;
    tick();
    chk_a("hwin_h2", 4'b0000, 8'h5A, 1'b0, 2'd2, 1'b0);
    tick();
    chk_a("hwin_none", 4'b0000, 8'h5A, 1'b0, 2'd2, 1'b0);

    // Request held through HOLD is granted on the edge after busy falls
    req_a = 4'b0010;
    data_a[15:8] = 8'hC3;
    tick();
    chk_a("held_g1", 4'b0010, 8'hC3, 1'b1, 2'd1, 1'b1);
    tick();
    chk_a("held_h1", 4'b0000, 8'hC3, 1'b0, 2'd1, 1'b1);
    tick();
    chk_a("held_h2", 4'b0000, 8'hC3, 1'b0, 2'd1, 1'b0);
    tick();
    chk_a("held_g2", 4'b0010, 8'hC3, 1'b1, 2'd1, 1'b1);

    // Reset during HOLD clears everything; ptr back to 0
    req_a = 4'b0001;
    reset = 1'b1;
    tick();
    chk_a("mrst", 4'b0000, 8'h00, 1'b0, 2'd0, 1'b0);
    reset = 1'b0;
    tick();
    chk_a("mrst_g", 4'b0001, 8'h20, 1'b1, 2'd0, 1'b1);

    // ptr after reset + grant 0 is 1: requesters 2 and 3 pending -> 2 wins after cooldown
    req_a = 4'b1100;
    tick();
    tick();
    tick();
    chk_a("post_rst", 4'b0100, 8'h5A, 1'b1, 2'd2, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
